// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch controller: FSM state encoding,
// datapath width and the buffered-instruction record.
package fetch_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] data;
    } fetch_inst_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-side handshakes: imem request/response channel and the decode-facing
// instruction channel. master = fetch controller, slave = memory/decode side.
interface fetch_ctrl_if #(
    parameter int XLEN = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_resp_valid;
    logic [XLEN-1:0] imem_resp_data;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst_pc;
    logic [XLEN-1:0] inst_data;

    modport master (
        output imem_req_valid,
        input  imem_req_ready,
        output imem_req_addr,
        input  imem_resp_valid,
        input  imem_resp_data,
        output inst_valid,
        input  inst_ready,
        output inst_pc,
        output inst_data
    );

    modport slave (
        input  imem_req_valid,
        output imem_req_ready,
        input  imem_req_addr,
        output imem_resp_valid,
        output imem_resp_data,
        input  inst_valid,
        output inst_ready,
        input  inst_pc,
        input  inst_data
    );
endinterface

// File: rtl/fetch_ctrl_chk.sv
// Protocol checks for the fetch controller: no responses while nothing can be
// outstanding, stable request and stable buffered instruction under backpressure.
module fetch_ctrl_chk
    import fetch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input logic            clk,
    input logic            rst,
    input logic [1:0]      state,
    input logic            redirect_valid,
    input logic            imem_req_valid,
    input logic            imem_req_ready,
    input logic [XLEN-1:0] imem_req_addr,
    input logic            imem_resp_valid,
    input logic            inst_valid,
    input logic            inst_ready,
    input logic [XLEN-1:0] inst_pc,
    input logic [XLEN-1:0] inst_data
);

    logic resp_in_idle_s;
    logic req_stall_s;
    logic inst_stall_s;

    assign resp_in_idle_s = imem_resp_valid && ((state == BOOT) || (state == REQ));
    assign req_stall_s    = imem_req_valid && !imem_req_ready && !redirect_valid;
    assign inst_stall_s   = inst_valid && !inst_ready && !redirect_valid;

    a_no_resp_when_idle: assert property (@(posedge clk) disable iff (rst)
        !resp_in_idle_s)
        else $error("fetch_ctrl protocol: imem response with no request outstanding");

    a_req_only_in_req: assert property (@(posedge clk) disable iff (rst)
        imem_req_valid |-> (state == REQ))
        else $error("fetch_ctrl protocol: request raised outside REQ");

    a_req_held: assert property (@(posedge clk) disable iff (rst)
        req_stall_s |=> (imem_req_valid && $stable(imem_req_addr)))
        else $error("fetch_ctrl protocol: request dropped or changed while stalled");

    a_inst_held: assert property (@(posedge clk) disable iff (rst)
        inst_stall_s |=> (inst_valid && $stable(inst_pc) && $stable(inst_data)))
        else $error("fetch_ctrl protocol: buffered instruction changed under backpressure");

endmodule

// File: rtl/fetch_inst_buf.sv
// One-entry valid/ready output buffer toward decode. Flush wins over load and
// consume so a redirect never lets an old instruction survive the edge.
module fetch_inst_buf
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_valid,
    input  fetch_inst_t load_inst,
    input  logic        flush,
    input  logic        inst_ready,
    output logic        inst_valid,
    output fetch_inst_t inst
);

    logic        valid_r;
    fetch_inst_t inst_r;

    // Occupancy and payload register; payload only changes on load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= 1'b0;
            inst_r  <= '0;
        end else if (flush) begin
            valid_r <= 1'b0;
            inst_r  <= inst_r;
        end else if (load_valid) begin
            valid_r <= 1'b1;
            inst_r  <= load_inst;
        end else if (valid_r && inst_ready) begin
            valid_r <= 1'b0;
            inst_r  <= inst_r;
        end else begin
            valid_r <= valid_r;
            inst_r  <= inst_r;
        end
    end

    assign inst_valid = valid_r;
    assign inst       = inst_r;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, issues one imem request at a
// time, squashes wrong-path responses after a redirect and feeds decode.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          XLEN         = fetch_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] pred_query_pc,
    input  logic [XLEN-1:0] pred_next_pc,
    fetch_ctrl_if.master    bus
);

    localparam logic [1:0] ST_BOOT  = BOOT;
    localparam logic [1:0] ST_REQ   = REQ;
    localparam logic [1:0] ST_WAIT  = WAIT;
    localparam logic [1:0] ST_DRAIN = DRAIN;

    logic [1:0]      state_r;
    logic [1:0]      state_nxt_s;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] pc_nxt_s;
    logic [XLEN-1:0] req_pc_r;
    logic [XLEN-1:0] req_pc_nxt_s;
    logic            req_valid_s;
    logic            accept_s;
    logic            load_s;
    fetch_inst_t     load_inst_s;
    fetch_inst_t     buf_inst_s;
    logic            buf_valid_s;

    // A request may go out whenever the buffer will have room for its response.
    assign req_valid_s = (state_r == ST_REQ) && (!buf_valid_s || bus.inst_ready);
    assign accept_s    = req_valid_s && bus.imem_req_ready;

    // Next-state, next-PC and buffer-load decision.
    always_comb begin
        state_nxt_s  = state_r;
        pc_nxt_s     = pc_r;
        req_pc_nxt_s = req_pc_r;
        load_s       = 1'b0;
        case (state_r)
            ST_BOOT: begin
                state_nxt_s = ST_REQ;
                if (redirect_valid) begin
                    pc_nxt_s = redirect_pc;
                end else begin
                    pc_nxt_s = pc_r;
                end
            end
            ST_REQ: begin
                if (accept_s) begin
                    req_pc_nxt_s = pc_r;
                    if (redirect_valid) begin
                        // The request just accepted is already wrong-path.
                        pc_nxt_s    = redirect_pc;
                        state_nxt_s = ST_DRAIN;
                    end else begin
                        pc_nxt_s    = pred_next_pc;
                        state_nxt_s = ST_WAIT;
                    end
                end else if (redirect_valid) begin
                    pc_nxt_s = redirect_pc;
                end else begin
                    pc_nxt_s = pc_r;
                end
            end
            ST_WAIT: begin
                if (redirect_valid) begin
                    pc_nxt_s    = redirect_pc;
                    state_nxt_s = bus.imem_resp_valid ? ST_REQ : ST_DRAIN;
                end else if (bus.imem_resp_valid) begin
                    load_s      = 1'b1;
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_DRAIN: begin
                if (redirect_valid) begin
                    pc_nxt_s = redirect_pc;
                end else begin
                    pc_nxt_s = pc_r;
                end
                if (bus.imem_resp_valid) begin
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                state_nxt_s = ST_BOOT;
                pc_nxt_s    = RESET_VECTOR;
            end
        endcase
    end

    // FSM and PC registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_BOOT;
            pc_r     <= RESET_VECTOR;
            req_pc_r <= '0;
        end else begin
            state_r  <= state_nxt_s;
            pc_r     <= pc_nxt_s;
            req_pc_r <= req_pc_nxt_s;
        end
    end

    assign load_inst_s = '{pc: req_pc_r, data: bus.imem_resp_data};

    fetch_inst_buf u_inst_buf (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_s),
        .load_inst  (load_inst_s),
        .flush      (redirect_valid),
        .inst_ready (bus.inst_ready),
        .inst_valid (buf_valid_s),
        .inst       (buf_inst_s)
    );

    assign pred_query_pc      = pc_r;
    assign bus.imem_req_valid = req_valid_s;
    assign bus.imem_req_addr  = pc_r;
    assign bus.inst_valid     = buf_valid_s;
    assign bus.inst_pc        = buf_inst_s.pc;
    assign bus.inst_data      = buf_inst_s.data;

    fetch_ctrl_chk #(.XLEN(XLEN)) u_chk (
        .clk             (clk),
        .rst             (rst),
        .state           (state_r),
        .redirect_valid  (redirect_valid),
        .imem_req_valid  (req_valid_s),
        .imem_req_ready  (bus.imem_req_ready),
        .imem_req_addr   (pc_r),
        .imem_resp_valid (bus.imem_resp_valid),
        .inst_valid      (buf_valid_s),
        .inst_ready      (bus.inst_ready),
        .inst_pc         (buf_inst_s.pc),
        .inst_data       (buf_inst_s.data)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: sequential fetch, backpressure, redirects in
// WAIT and on accept, predictor override, PC wrap and mid-WAIT async reset.
module tb_fetch_ctrl;
    import fetch_pkg::*;

    localparam logic [31:0] RV = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] pred_query_pc;
    logic [31:0] pred_next_pc;
    logic        pred_force;
    logic [31:0] pred_val;
    int          n_tests = 0;
    int          n_fail  = 0;

    fetch_ctrl_if #(.XLEN(32)) bus ();

    fetch_ctrl #(.RESET_VECTOR(RV), .XLEN(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pred_query_pc  (pred_query_pc),
        .pred_next_pc   (pred_next_pc),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    // Predictor stand-in: sequential +4 unless a target is forced.
    assign pred_next_pc = pred_force ? pred_val : pred_query_pc + 32'd4;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_req(input string tag, input logic v, input logic [31:0] a);
        chk1({tag, "_req_valid"}, bus.imem_req_valid, v);
        if (v) chk32({tag, "_req_addr"}, bus.imem_req_addr, a);
    endtask

    task automatic chk_inst(input string tag, input logic [31:0] pc, input logic [31:0] data);
        chk1({tag, "_inst_valid"}, bus.inst_valid, 1'b1);
        chk32({tag, "_inst_pc"}, bus.inst_pc, pc);
        chk32({tag, "_inst_data"}, bus.inst_data, data);
    endtask

    task automatic resp_cycle(input logic [31:0] d);
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = d;
        cyc();
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'd0;
    endtask

    initial begin
        rst                 = 1'b1;
        redirect_valid      = 1'b0;
        redirect_pc         = 32'd0;
        pred_force          = 1'b0;
        pred_val            = 32'd0;
        bus.imem_req_ready  = 1'b1;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'd0;
        bus.inst_ready      = 1'b1;
        #2;
        // Reset values
        chk1("rst_req_valid", bus.imem_req_valid, 1'b0);
        chk32("rst_req_addr", bus.imem_req_addr, RV);
        chk32("rst_query", pred_query_pc, RV);
        chk1("rst_inst_valid", bus.inst_valid, 1'b0);
        chk32("rst_inst_pc", bus.inst_pc, 32'd0);
        chk32("rst_inst_data", bus.inst_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk1("boot_no_req", bus.imem_req_valid, 1'b0);

        // Sequential fetch 0x100, 0x104, 0x108
        cyc();
        chk_req("t1_r0", 1'b1, 32'h100);
        cyc();
        chk_req("t1_w0", 1'b0, 32'h0);
        resp_cycle(32'hA000_0100);
        chk_inst("t1_i0", 32'h100, 32'hA000_0100);
        chk_req("t1_r1", 1'b1, 32'h104);
        cyc();
        chk1("t1_consumed", bus.inst_valid, 1'b0);
        resp_cycle(32'hA000_0104);
        chk_inst("t1_i1", 32'h104, 32'hA000_0104);
        chk_req("t1_r2", 1'b1, 32'h108);
        cyc();
        resp_cycle(32'hA000_0108);
        chk_inst("t1_i2", 32'h108, 32'hA000_0108);

        // Backpressure holds the buffer and blocks the next request
        bus.inst_ready = 1'b0;
        #1;
        chk_req("t2_block", 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk_inst("t2_hold", 32'h108, 32'hA000_0108);
            chk_req("t2_hold", 1'b0, 32'h0);
        end
        bus.inst_ready = 1'b1;
        #1;
        chk_req("t2_release", 1'b1, 32'h10C);
        cyc();
        chk1("t2_wait_empty", bus.inst_valid, 1'b0);

        // Redirect in WAIT, late response dropped in DRAIN
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        cyc();
        redirect_valid = 1'b0;
        chk_req("t3_drain", 1'b0, 32'h0);
        chk32("t3_query", pred_query_pc, 32'h200);
        cyc();
        chk_req("t3_drain1", 1'b0, 32'h0);
        resp_cycle(32'hBAD0_010C);
        chk1("t3_dropped", bus.inst_valid, 1'b0);
        chk_req("t3_refetch", 1'b1, 32'h200);
        cyc();
        resp_cycle(32'hA000_0200);
        chk_inst("t3_i", 32'h200, 32'hA000_0200);
        chk_req("t3_next", 1'b1, 32'h204);

        // Redirect on the accepting cycle: 0x204 must never be delivered
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        #1;
        chk_req("t4_req_indep", 1'b1, 32'h204);
        cyc();
        redirect_valid = 1'b0;
        chk1("t4_flushed", bus.inst_valid, 1'b0);
        chk_req("t4_drain", 1'b0, 32'h0);
        resp_cycle(32'hBAD0_0204);
        chk1("t4_dropped", bus.inst_valid, 1'b0);
        chk_req("t4_refetch", 1'b1, 32'h300);

        // Predictor target and PC wrap
        pred_force = 1'b1;
        pred_val   = 32'h400;
        cyc();
        pred_force = 1'b0;
        chk32("t5_pred_pc", pred_query_pc, 32'h400);
        resp_cycle(32'hA000_0300);
        chk_inst("t5_i", 32'h300, 32'hA000_0300);
        chk_req("t5_target", 1'b1, 32'h400);
        bus.imem_req_ready = 1'b0;
        redirect_valid     = 1'b1;
        redirect_pc        = 32'hFFFF_FFFC;
        #1;
        chk1("t5_valid_indep_ready", bus.imem_req_valid, 1'b1);
        cyc();
        redirect_valid     = 1'b0;
        bus.imem_req_ready = 1'b1;
        chk1("t5_flush", bus.inst_valid, 1'b0);
        chk_req("t5_top", 1'b1, 32'hFFFF_FFFC);
        cyc();
        chk32("t5_wrap", pred_query_pc, 32'h0);
        resp_cycle(32'hA000_FFFC);
        chk_inst("t5_iw", 32'hFFFF_FFFC, 32'hA000_FFFC);
        chk_req("t5_zero", 1'b1, 32'h0);

        // Async reset while WAITing for a response
        cyc();
        chk_req("t6_wait", 1'b0, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        chk1("t6_inst_valid", bus.inst_valid, 1'b0);
        chk1("t6_req_valid", bus.imem_req_valid, 1'b0);
        chk32("t6_addr", bus.imem_req_addr, RV);
        chk32("t6_inst_pc", bus.inst_pc, 32'd0);
        cyc();
        chk_req("t6_in_rst", 1'b0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk1("t6_boot", bus.imem_req_valid, 1'b0);
        cyc();
        chk_req("t6_restart", 1'b1, RV);
        chk1("t6_no_inst", bus.inst_valid, 1'b0);
        cyc();
        resp_cycle(32'hA000_0101);
        chk_inst("t6_i", RV, 32'hA000_0101);
        chk_req("t6_next", 1'b1, 32'h104);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Sequences instruction fetch between the PC/branch-prediction datapath and the instruction memory port. It owns the architectural fetch PC and issues one imem request at a time with a valid/ready handshake. It presents fetched instructions to decode through a one-entry output buffer. It applies redirects from execute and discards stale imem responses still in flight, so decode never sees a wrong-path instruction fetched before the redirect.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC of the first fetch after reset.
XLEN, 32, address and instruction width.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  asynchronous, active-high reset.
redirect_valid  in  1  execute-stage redirect (mispredict or exception) this cycle.
redirect_pc  in  XLEN  target PC when redirect_valid.
pred_query_pc  out  XLEN  PC presented to the BTB; equals the current fetch PC register.
pred_next_pc  in  XLEN  combinational predictor result for pred_query_pc (BTB target or +4).
imem_req_valid  out  1  fetch request valid.
imem_req_ready  in  1  imem accepts the request this cycle.
imem_req_addr  out  XLEN  request address; equals the fetch PC.
imem_resp_valid  in  1  response for the oldest outstanding request.
imem_resp_data  in  XLEN  instruction word.
inst_valid  out  1  output buffer holds an instruction.
inst_ready  in  1  decode accepts the instruction.
inst_pc  out  XLEN  PC of the buffered instruction.
inst_data  out  XLEN  buffered instruction word.

Behaviour:
- Reset (async): state=BOOT, pc=RESET_VECTOR, buffer empty. All outputs 0, except pred_query_pc and imem_req_addr, which equal RESET_VECTOR.
- States: BOOT, REQ, WAIT, DRAIN.
- BOOT: one cycle with no request, then REQ. A redirect in BOOT loads pc and the block still goes to REQ.
- REQ: imem_req_valid = buffer empty, or buffer being consumed this cycle (inst_valid & inst_ready). imem_req_valid never depends on imem_req_ready or redirect_valid.
  - On accept (valid & ready): req_pc<=pc, pc<=pred_next_pc, go to WAIT.
  - Redirect with no accept: pc<=redirect_pc, stay in REQ.
  - Redirect on the same cycle as an accept: pc<=redirect_pc, go to DRAIN (the accepted request is stale).
- WAIT:
  - resp_valid and no redirect: write {req_pc, resp_data} into the buffer, go to REQ.
  - Redirect with resp_valid the same cycle: drop the response, pc<=redirect_pc, go to REQ.
  - Redirect without resp_valid: pc<=redirect_pc, go to DRAIN.
- DRAIN: no request. On resp_valid, drop the response and go to REQ. A further redirect in DRAIN only reloads pc.
- Output buffer:
  - Load and consume in the same cycle is legal.
  - Contents are held stable while inst_valid & !inst_ready.
  - Redirect clears inst_valid on the next edge, even if inst_ready was high that cycle. Decode flushes on the same redirect, so that handshake is void.
- Throughput: at most one outstanding request. Best case is one instruction every 2 cycles with zero-latency imem.
- Latency: the first imem request is issued the cycle after rst deasserts plus one BOOT cycle. The response reaches inst_valid one cycle after imem_resp_valid.
- PC arithmetic is modulo 2^XLEN; 32'hFFFF_FFFC + 4 wraps to 0 with no error.
- Responses are never ignored outside DRAIN or WAIT+redirect. A resp_valid in REQ or BOOT is a protocol error and fires an assertion.
- Reset mid-operation: any outstanding request is forgotten. The imem side must be reset together with this block.

Decomposition:
- Package fetch_pkg holds:
  - the fetch_state_e enum {BOOT, REQ, WAIT, DRAIN};
  - the XLEN constant;
  - the fetch_inst_t struct {pc, data}.
- One natural sub-module: fetch_inst_buf, a one-entry valid/ready buffer with a flush input.
- The FSM and PC register stay in fetch_ctrl. The predictor is external, connected via pred_query_pc/pred_next_pc.

Test Plan:
1. Reset: RESET_VECTOR=0x100, imem always ready, 1-cycle response, pred=+4 → requests 0x100, 0x104, 0x108 every 2 cycles; inst_pc matches each.
2. Backpressure: inst_ready=0 for 5 cycles after first instruction → inst_pc/inst_data stable, no new imem_req_valid until ready=1, then the next request is 0x104.
3. Redirect in WAIT, response 3 cycles late: redirect_pc=0x200 → enters DRAIN, the late response is dropped (inst_valid stays 0), next request is 0x200.
4. Redirect on the same cycle as a request accept at 0x104 → DRAIN, 0x104 data is never delivered, next request is 0x300.
5. Predictor: pred_next_pc=0x400 for query 0x108 → request after 0x108 is 0x400; at pc=0xFFFF_FFFC with +4 the next request is 0x0000_0000.
6. Async rst asserted in WAIT mid-cycle → outputs clear immediately, no delivery of the pending response, fetch restarts at RESET_VECTOR after BOOT.
